// File: rtl/backlight_fade_ctrl.sv
// backlight_fade_ctrl: ramps the PWM duty code one LSB per prescaler tick toward the effective target; optional auto-dim via IDLE_DIM_EN
module backlight_fade_ctrl #(
   parameter int STEP_DIV      = 4096,
   parameter int DEFAULT_LEVEL = 24,
   parameter int DIM_LEVEL     = 4,
   parameter int IDLE_TIMEOUT  = 1 << 20
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       Enable,
   input  logic [4:0] Target_Val,
   input  logic       Target_WR,
   input  logic       Activity,
   output logic [4:0] Duty_Val,
   output logic       Busy,
   output logic       Dimmed
);
   localparam int PW = $clog2(STEP_DIV);
   localparam logic [PW-1:0] PS_MAX = PW'(STEP_DIV - 1);
   localparam logic [4:0] DEF_L = 5'(DEFAULT_LEVEL);
   localparam logic [4:0] DIM_L = 5'(DIM_LEVEL);
   typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;
   logic [PW-1:0] ps_q, ps_d;
   logic [4:0] duty_q, duty_d, tgt_q, tgt_d, et;
   logic dim_q, tick;
   state_e state;
`ifdef IDLE_DIM_EN
   localparam int IW = $clog2(IDLE_TIMEOUT);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT - 1);
   logic [IW-1:0] idle_q, idle_d;
   logic dim_d;
   // idle counter runs while lit and undimmed; user activity, writes or disable clear it and undim
   always_comb begin
      idle_d = idle_q;
      dim_d  = dim_q;
      if (!Enable || Activity || Target_WR) begin
         idle_d = '0;
         dim_d  = 1'b0;
      end else if (!dim_q) begin
         if (idle_q == IDLE_MAX) dim_d = 1'b1;
         else idle_d = idle_q + 1'b1;
      end
   end
   // idle counter and dim flag registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         idle_q <= '0;
         dim_q  <= 1'b0;
      end else begin
         idle_q <= idle_d;
         dim_q  <= dim_d;
      end
   end
`else
   logic unused_activity;
   assign unused_activity = Activity;
   assign dim_q = 1'b0;
`endif
   // effective target, ramp direction and next duty; saturation is implicit since ET stays in 0..31
   always_comb begin
      et     = !Enable ? 5'd0 : (dim_q && DIM_L < tgt_q) ? DIM_L : tgt_q;
      state  = duty_q < et ? UP : duty_q > et ? DOWN : IDLE;
      tick   = ps_q == PS_MAX;
      ps_d   = tick ? '0 : ps_q + 1'b1;
      duty_d = !tick ? duty_q : state == UP ? duty_q + 5'd1 : state == DOWN ? duty_q - 5'd1 : duty_q;
      tgt_d  = Target_WR ? Target_Val : tgt_q;
   end
   // prescaler, duty and target registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ps_q   <= '0;
         duty_q <= 5'd0;
         tgt_q  <= DEF_L;
      end else begin
         ps_q   <= ps_d;
         duty_q <= duty_d;
         tgt_q  <= tgt_d;
      end
   end
   assign Duty_Val = duty_q;
   assign Busy     = nRST && state != IDLE;
   assign Dimmed   = dim_q;
endmodule
